// File: rtl/revelar_pkg.sv
// Shared types, board constants and neighbour helpers for the reveal logic.
package revelar_pkg;

  localparam int N      = 8;
  localparam int CELDAS = N * N;
  localparam int IDX_W  = 6;
  localparam int CNT_W  = 7;

  typedef enum logic [2:0] {
    SIN_TABLERO = 3'd0,
    JUGANDO     = 3'd1,
    REVELA      = 3'd2,
    BARRIDO     = 3'd3,
    PERDIDO     = 3'd4,
    GANADO      = 3'd5
  } estado_t;

  // Linear cell index; with N=8 this is simply {fila, col}.
  function automatic logic [IDX_W-1:0] idx(input logic [2:0] fila, input logic [2:0] col);
    return {fila, col};
  endfunction

  // True when the neighbour at (dfila, dcol) stays inside the board (no wrap).
  function automatic logic vecino_valido(input logic [IDX_W-1:0] celda, input int dfila, input int dcol);
    int f;
    int c;
    f = int'(celda[5:3]) + dfila;
    c = int'(celda[2:0]) + dcol;
    return (f >= 0) && (f < N) && (c >= 0) && (c < N);
  endfunction

  // Index of the neighbour; only meaningful when vecino_valido() holds.
  function automatic logic [IDX_W-1:0] vecino_idx(input logic [IDX_W-1:0] celda, input int dfila, input int dcol);
    int f;
    int c;
    f = int'(celda[5:3]) + dfila;
    c = int'(celda[2:0]) + dcol;
    return IDX_W'(f * N + c);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [CELDAS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < CELDAS; k++) n = n + CNT_W'(v[k]);
    return n;
  endfunction

endpackage

// File: rtl/es_cero.sv
// Flags a cell whose in-board neighbourhood holds no mine.
module es_cero
  import revelar_pkg::*;
(
  input  logic [CELDAS-1:0] i_minas,
  input  logic [IDX_W-1:0]  i_idx,
  output logic              o_cero
);

  // Any in-board neighbour carrying a mine clears the flag.
  always_comb begin
    o_cero = 1'b1;
    for (int df = -1; df <= 1; df++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(df == 0 && dc == 0) && vecino_valido(i_idx, df, dc)) begin
          if (i_minas[vecino_idx(i_idx, df, dc)]) o_cero = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/revelar_casillas.sv
// Player reveal logic: latches the mine board, reveals cells, floods zero
// regions with raster sweeps and reports loss/win.
//
// state       | meaning
// SIN_TABLERO | no board loaded yet, selects ignored
// JUGANDO     | waiting for a player select
// REVELA      | one-cycle evaluation of the selected cell
// BARRIDO     | raster sweep, one cell per cycle, until a sweep makes no change
// PERDIDO     | mine hit, frozen until carga
// GANADO      | all safe cells revealed, frozen until carga
module revelar_casillas
  import revelar_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                carga,
  input  logic [CELDAS-1:0]   minas_in,
  input  logic [2:0]          sel_fila,
  input  logic [2:0]          sel_col,
  input  logic                sel_valido,
  output logic                sel_listo,
  output logic [CELDAS-1:0]   revelado,
  output logic                ocupado,
  output logic                perdido,
  output logic                ganado,
  output logic [CNT_W-1:0]    minas_total,
  output logic [CNT_W-1:0]    revelados_cnt
);

  estado_t             r_estado;
  estado_t             w_estado_nxt;
  logic [CELDAS-1:0]   r_minas;
  logic [CELDAS-1:0]   r_revelado;
  logic [CNT_W-1:0]    r_tot;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_cambio;
  logic                r_perdido;
  logic                r_ganado;

  logic [CELDAS-1:0]   w_minas_nxt;
  logic [CELDAS-1:0]   w_revelado_nxt;
  logic [CNT_W-1:0]    w_tot_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_cambio_nxt;
  logic                w_perdido_nxt;
  logic                w_ganado_nxt;
  logic                w_a_jugar;
  logic                w_cambio_act;
  logic [CNT_W-1:0]    w_tot_carga;
  logic [CNT_W-1:0]    w_objetivo;

  logic [CELDAS-1:0]   w_cero;
  logic                w_vecino_cero;
  logic                w_revela_barrido;

  // Zero-mask of the whole latched board; serves both the REVELA cell and
  // the neighbour test of the sweep.
  for (genvar g = 0; g < CELDAS; g++) begin : g_cero
    es_cero u_es_cero (
      .i_minas (r_minas),
      .i_idx   (IDX_W'(g)),
      .o_cero  (w_cero[g])
    );
  end

  assign w_tot_carga = popcount(minas_in);
  assign w_objetivo  = CNT_W'(CELDAS) - r_tot;

  // Sweep test: some in-board neighbour of the scan cell is revealed and zero.
  always_comb begin
    w_vecino_cero = 1'b0;
    for (int df = -1; df <= 1; df++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(df == 0 && dc == 0) && vecino_valido(r_idx, df, dc)) begin
          if (r_revelado[vecino_idx(r_idx, df, dc)] && w_cero[vecino_idx(r_idx, df, dc)])
            w_vecino_cero = 1'b1;
        end
      end
    end
  end

  assign w_revela_barrido = !r_revelado[r_idx] && !r_minas[r_idx] && w_vecino_cero;

  // Next-state and datapath updates; carga overrides everything.
  always_comb begin
    w_estado_nxt   = r_estado;
    w_minas_nxt    = r_minas;
    w_revelado_nxt = r_revelado;
    w_tot_nxt      = r_tot;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_cambio_nxt   = r_cambio;
    w_perdido_nxt  = r_perdido;
    w_ganado_nxt   = r_ganado;
    w_a_jugar      = 1'b0;
    w_cambio_act   = r_cambio | w_revela_barrido;

    if (carga) begin
      w_minas_nxt    = minas_in;
      w_tot_nxt      = w_tot_carga;
      w_revelado_nxt = '0;
      w_cnt_nxt      = '0;
      w_idx_nxt      = '0;
      w_cambio_nxt   = 1'b0;
      w_perdido_nxt  = 1'b0;
      w_ganado_nxt   = (w_tot_carga == CNT_W'(CELDAS));
      w_estado_nxt   = (w_tot_carga == CNT_W'(CELDAS)) ? GANADO : JUGANDO;
    end else begin
      case (r_estado)
        JUGANDO: begin
          if (sel_valido) begin
            w_idx_nxt    = idx(sel_fila, sel_col);
            w_estado_nxt = REVELA;
          end
        end
        REVELA: begin
          if (r_revelado[r_idx]) begin
            w_a_jugar = 1'b1;
          end else if (r_minas[r_idx]) begin
            w_revelado_nxt = r_revelado | r_minas;
            w_perdido_nxt  = 1'b1;
            w_estado_nxt   = PERDIDO;
          end else begin
            w_revelado_nxt[r_idx] = 1'b1;
            w_cnt_nxt             = r_cnt + 1'b1;
            if (w_cero[r_idx]) begin
              w_idx_nxt    = '0;
              w_cambio_nxt = 1'b0;
              w_estado_nxt = BARRIDO;
            end else begin
              w_a_jugar = 1'b1;
            end
          end
        end
        BARRIDO: begin
          if (w_revela_barrido) begin
            w_revelado_nxt[r_idx] = 1'b1;
            w_cnt_nxt             = r_cnt + 1'b1;
          end
          if (r_idx == IDX_W'(CELDAS - 1)) begin
            // A reveal on the last cell counts as a change for this sweep.
            if (w_cambio_act) begin
              w_idx_nxt    = '0;
              w_cambio_nxt = 1'b0;
            end else begin
              w_a_jugar = 1'b1;
            end
          end else begin
            w_idx_nxt    = r_idx + 1'b1;
            w_cambio_nxt = w_cambio_act;
          end
        end
        default: ;
      endcase

      if (w_a_jugar) begin
        if (w_cnt_nxt == w_objetivo) begin
          w_ganado_nxt = 1'b1;
          w_estado_nxt = GANADO;
        end else begin
          w_estado_nxt = JUGANDO;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= SIN_TABLERO;
    else        r_estado <= w_estado_nxt;
  end

  // Board, counters and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_minas    <= '0;
      r_revelado <= '0;
      r_tot      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_cambio   <= 1'b0;
      r_perdido  <= 1'b0;
      r_ganado   <= 1'b0;
    end else begin
      r_minas    <= w_minas_nxt;
      r_revelado <= w_revelado_nxt;
      r_tot      <= w_tot_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_cambio   <= w_cambio_nxt;
      r_perdido  <= w_perdido_nxt;
      r_ganado   <= w_ganado_nxt;
    end
  end

  assign sel_listo     = (r_estado == JUGANDO);
  assign ocupado       = (r_estado == REVELA) || (r_estado == BARRIDO);
  assign revelado      = r_revelado;
  assign perdido       = r_perdido;
  assign ganado        = r_ganado;
  assign minas_total   = r_tot;
  assign revelados_cnt = r_cnt;

endmodule

// File: tb/tb_revelar_casillas.sv
// Bench for revelar_casillas: directed scenarios plus random games checked
// against a flood-fill model of the board.
module tb_revelar_casillas;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        carga;
  logic [63:0] minas_in;
  logic [2:0]  sel_fila;
  logic [2:0]  sel_col;
  logic        sel_valido;
  logic        sel_listo;
  logic [63:0] revelado;
  logic        ocupado;
  logic        perdido;
  logic        ganado;
  logic [6:0]  minas_total;
  logic [6:0]  revelados_cnt;

  int errors = 0;
  int checks = 0;

  // Reference board model.
  bit [63:0] m_minas;
  bit [63:0] m_rev;
  int        m_cnt;
  bit        m_perd;
  bit        m_gan;

  revelar_casillas dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .carga         (carga),
    .minas_in      (minas_in),
    .sel_fila      (sel_fila),
    .sel_col       (sel_col),
    .sel_valido    (sel_valido),
    .sel_listo     (sel_listo),
    .revelado      (revelado),
    .ocupado       (ocupado),
    .perdido       (perdido),
    .ganado        (ganado),
    .minas_total   (minas_total),
    .revelados_cnt (revelados_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_es_mina(int f, int c);
    if (f < 0 || f > 7 || c < 0 || c > 7) return 1'b0;
    return m_minas[f*8 + c];
  endfunction

  function automatic bit m_cero(int f, int c);
    for (int df = -1; df <= 1; df++)
      for (int dc = -1; dc <= 1; dc++)
        if ((df != 0 || dc != 0) && m_es_mina(f + df, c + dc)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_carga(input bit [63:0] b);
    m_minas = b;
    m_rev   = '0;
    m_cnt   = 0;
    m_perd  = 1'b0;
    m_gan   = ($countones(b) == 64);
  endtask

  // Select, then breadth-first flood from a zero cell.
  task automatic m_select(input int f, input int c);
    int i;
    int q[$];
    if (m_gan || m_perd) return;
    i = f*8 + c;
    if (m_rev[i]) begin
    end else if (m_minas[i]) begin
      m_rev  = m_rev | m_minas;
      m_perd = 1'b1;
      return;
    end else begin
      m_rev[i] = 1'b1;
      m_cnt++;
      q.push_back(i);
      while (q.size() > 0) begin
        int k;
        int kf;
        int kc;
        k  = q.pop_front();
        kf = k / 8;
        kc = k % 8;
        if (m_cero(kf, kc)) begin
          for (int df = -1; df <= 1; df++)
            for (int dc = -1; dc <= 1; dc++) begin
              int nf;
              int nc;
              nf = kf + df;
              nc = kc + dc;
              if ((df != 0 || dc != 0) && nf >= 0 && nf < 8 && nc >= 0 && nc < 8) begin
                if (!m_rev[nf*8 + nc] && !m_minas[nf*8 + nc]) begin
                  m_rev[nf*8 + nc] = 1'b1;
                  m_cnt++;
                  q.push_back(nf*8 + nc);
                end
              end
            end
        end
      end
    end
    if (m_cnt == 64 - $countones(m_minas)) m_gan = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_carga(input bit [63:0] b);
    carga    = 1'b1;
    minas_in = b;
    tick();
    carga    = 1'b0;
    m_carga(b);
  endtask

  task automatic select_pulse(input int f, input int c);
    sel_fila   = 3'(f);
    sel_col    = 3'(c);
    sel_valido = 1'b1;
    tick();
    sel_valido = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (ocupado === 1'b1 && cyc < 5000) begin
      tick();
      cyc++;
    end
    checks++;
    if (ocupado !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: ocupado=%b after %0d cycles, required 0", ocupado, cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; carga = 1'b0; sel_valido = 1'b0; minas_in = '0; sel_fila = '0; sel_col = '0;
    tick(); tick();
    checks++;
    if (revelado !== 64'h0 || revelados_cnt !== 7'd0 || minas_total !== 7'd0) begin
      errors++;
      $display("FAIL reset_regs: revelado=%h cnt=%0d tot=%0d, required 0/0/0", revelado, revelados_cnt, minas_total);
    end
    checks++;
    if ({sel_listo, ocupado, perdido, ganado} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: listo/ocup/perd/gan=%b, required 0000", {sel_listo, ocupado, perdido, ganado});
    end
    rst_n = 1'b1;
    tick();
    select_pulse(2, 2);
    tick();
    checks++;
    if (revelado !== 64'h0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL no_board_select: revelado=%h ocupado=%b, required 0/0", revelado, ocupado);
    end
  endtask

  task automatic test_mine_hit();
    drive_carga(64'h200);
    checks++;
    if (minas_total !== 7'd1 || sel_listo !== 1'b1) begin
      errors++;
      $display("FAIL hit_load: tot=%0d listo=%b, required 1/1", minas_total, sel_listo);
    end
    select_pulse(1, 1);
    checks++;
    if (ocupado !== 1'b1 || perdido !== 1'b0) begin
      errors++;
      $display("FAIL hit_revela: ocupado=%b perdido=%b, required 1/0", ocupado, perdido);
    end
    tick();
    m_select(1, 1);
    checks++;
    if (perdido !== 1'b1 || revelado !== 64'h200 || sel_listo !== 1'b0) begin
      errors++;
      $display("FAIL hit_lost: perdido=%b revelado=%h listo=%b, required 1/0200/0", perdido, revelado, sel_listo);
    end
    select_pulse(0, 0);
    tick();
    checks++;
    if (revelado !== 64'h200 || perdido !== 1'b1 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL hit_frozen: revelado=%h perdido=%b ocupado=%b, required 0200/1/0", revelado, perdido, ocupado);
    end
  endtask

  task automatic test_numbered_repeat();
    int cyc;
    drive_carga(64'h1);
    select_pulse(0, 1);
    wait_idle(cyc);
    checks++;
    if (cyc !== 1 || revelado !== 64'h2 || revelados_cnt !== 7'd1 || sel_listo !== 1'b1) begin
      errors++;
      $display("FAIL numbered: cyc=%0d revelado=%h cnt=%0d listo=%b, required 1/2/1/1", cyc, revelado, revelados_cnt, sel_listo);
    end
    select_pulse(0, 1);
    wait_idle(cyc);
    checks++;
    if (cyc !== 1 || revelado !== 64'h2 || revelados_cnt !== 7'd1 || ganado !== 1'b0) begin
      errors++;
      $display("FAIL repeat_select: cyc=%0d revelado=%h cnt=%0d ganado=%b, required 1/2/1/0", cyc, revelado, revelados_cnt, ganado);
    end
  endtask

  task automatic test_carga_priority();
    carga = 1'b1; minas_in = 64'h8000_0000_0000_0021;
    sel_fila = 3'd3; sel_col = 3'd3; sel_valido = 1'b1;
    tick();
    carga = 1'b0; sel_valido = 1'b0;
    m_carga(64'h8000_0000_0000_0021);
    checks++;
    if (revelado !== 64'h0 || revelados_cnt !== 7'd0 || minas_total !== 7'd3 || ocupado !== 1'b0 || sel_listo !== 1'b1) begin
      errors++;
      $display("FAIL carga_priority: revelado=%h cnt=%0d tot=%0d ocup=%b listo=%b, required 0/0/3/0/1",
               revelado, revelados_cnt, minas_total, ocupado, sel_listo);
    end
    tick();
    checks++;
    if (revelado !== 64'h0 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL carga_priority_hold: revelado=%h ocupado=%b, required 0/0", revelado, ocupado);
    end
  endtask

  task automatic test_flood_win();
    int cyc;
    drive_carga(64'h8000_0000_0000_0000);
    select_pulse(0, 0);
    m_select(0, 0);
    wait_idle(cyc);
    checks++;
    if (cyc < 65 || ((cyc - 1) % 64) != 0) begin
      errors++;
      $display("FAIL flood_length: busy cycles=%0d, required 1+64*k with k>=1", cyc);
    end
    checks++;
    if (revelado !== 64'h7fff_ffff_ffff_ffff || revelado !== m_rev) begin
      errors++;
      $display("FAIL flood_bitmap: revelado=%h, required %h", revelado, 64'h7fff_ffff_ffff_ffff);
    end
    checks++;
    if (revelados_cnt !== 7'd63 || ganado !== 1'b1 || sel_listo !== 1'b0 || perdido !== 1'b0) begin
      errors++;
      $display("FAIL flood_win: cnt=%0d ganado=%b listo=%b perdido=%b, required 63/1/0/0", revelados_cnt, ganado, sel_listo, perdido);
    end
  endtask

  task automatic test_full_and_empty();
    int cyc;
    drive_carga('1);
    checks++;
    if (ganado !== 1'b1 || minas_total !== 7'd64 || sel_listo !== 1'b0 || revelado !== 64'h0) begin
      errors++;
      $display("FAIL full_board: ganado=%b tot=%0d listo=%b revelado=%h, required 1/64/0/0", ganado, minas_total, sel_listo, revelado);
    end
    drive_carga('0);
    checks++;
    if (ganado !== 1'b0 || minas_total !== 7'd0 || sel_listo !== 1'b1) begin
      errors++;
      $display("FAIL empty_load: ganado=%b tot=%0d listo=%b, required 0/0/1", ganado, minas_total, sel_listo);
    end
    select_pulse(4, 5);
    wait_idle(cyc);
    checks++;
    if (revelado !== '1 || revelados_cnt !== 7'd64 || ganado !== 1'b1) begin
      errors++;
      $display("FAIL empty_flood: revelado=%h cnt=%0d ganado=%b, required all-ones/64/1", revelado, revelados_cnt, ganado);
    end
  endtask

  task automatic test_reset_mid_sweep();
    drive_carga(64'h8000_0000_0000_0000);
    select_pulse(0, 0);
    repeat (20) tick();
    checks++;
    if (ocupado !== 1'b1) begin
      errors++;
      $display("FAIL sweep_running: ocupado=%b, required 1", ocupado);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (revelado !== 64'h0 || ocupado !== 1'b0 || sel_listo !== 1'b0 || minas_total !== 7'd0 || revelados_cnt !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_sweep: revelado=%h ocup=%b listo=%b tot=%0d cnt=%0d, required 0/0/0/0/0",
               revelado, ocupado, sel_listo, minas_total, revelados_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (ocupado !== 1'b0 || sel_listo !== 1'b0 || revelado !== 64'h0) begin
      errors++;
      $display("FAIL after_reset_idle: ocup=%b listo=%b revelado=%h, required 0/0/0", ocupado, sel_listo, revelado);
    end
  endtask

  task automatic test_random_games();
    int cyc;
    for (int g = 0; g < 8; g++) begin
      bit [63:0] b;
      int nm;
      b  = '0;
      nm = $urandom_range(12, 3);
      for (int k = 0; k < nm; k++) b[$urandom_range(63, 0)] = 1'b1;
      drive_carga(b);
      checks++;
      if (minas_total !== 7'($countones(b))) begin
        errors++;
        $display("FAIL rnd_total: game %0d tot=%0d, required %0d", g, minas_total, $countones(b));
      end
      for (int s = 0; s < 25; s++) begin
        int f;
        int c;
        if (m_gan || m_perd) break;
        f = $urandom_range(7, 0);
        c = $urandom_range(7, 0);
        checks++;
        if (sel_listo !== 1'b1) begin
          errors++;
          $display("FAIL rnd_listo: game %0d step %0d listo=%b, required 1", g, s, sel_listo);
        end
        select_pulse(f, c);
        m_select(f, c);
        wait_idle(cyc);
        checks++;
        if (revelado !== m_rev || revelados_cnt !== 7'(m_cnt)) begin
          errors++;
          $display("FAIL rnd_board: game %0d step %0d revelado=%h cnt=%0d, required %h/%0d", g, s, revelado, revelados_cnt, m_rev, m_cnt);
        end
        checks++;
        if (perdido !== m_perd || ganado !== m_gan || sel_listo !== !(m_perd || m_gan)) begin
          errors++;
          $display("FAIL rnd_flags: game %0d step %0d perd=%b gan=%b listo=%b, required %b/%b/%b",
                   g, s, perdido, ganado, sel_listo, m_perd, m_gan, !(m_perd || m_gan));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mine_hit();
    test_numbered_repeat();
    test_carga_priority();
    test_flood_win();
    test_full_and_empty();
    test_reset_mid_sweep();
    test_random_games();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/revelar_casillas.md
Name: revelar_casillas

Overview:
- Consumer side of the mine-board generator: latches the 8x8 mine bitmap the generator produces and runs the player's reveal logic.
- Handles single-cell reveal and zero-region flood reveal by raster sweeps.
- Detects loss (mine hit) and win (all safe cells revealed).
- Sits between the board generator and the display/VGA path. The display reads `revelado` together with the generator's adjacency counts.

Parameters:
- N, 8, board side length; cells indexed idx = fila*N + col. Only N=8 is required to work.
- IDX_W, 6, log2(N*N), width of cell index.
- CNT_W, 7, width of the mine and revealed counters (holds 0..N*N).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- carga  in  1  one-cycle pulse; latch minas_in and start a new game
- minas_in  in  64  mine bitmap, bit idx=1 means a mine
- sel_fila  in  3  selected row
- sel_col  in  3  selected column
- sel_valido  in  1  player select request
- sel_listo  out  1  block can accept a select; transfer happens when sel_valido & sel_listo
- revelado  out  64  revealed-cell bitmap
- ocupado  out  1  reveal or sweep in progress
- perdido  out  1  game lost (sticky until carga/reset)
- ganado  out  1  game won (sticky until carga/reset)
- minas_total  out  7  popcount of latched bitmap
- revelados_cnt  out  7  number of revealed non-mine cells

Behaviour:
- Reset (async, rst_n=0):
  - State SIN_TABLERO.
  - revelado=0, minas_total=0, revelados_cnt=0.
  - sel_listo=0, ocupado=0, perdido=0, ganado=0.
  - Internal mine register cleared.
  - Reset mid-sweep abandons the sweep immediately.
- States: SIN_TABLERO, JUGANDO, REVELA, BARRIDO, PERDIDO, GANADO.
- carga:
  - Accepted in any state; has priority over every other event, including a simultaneous select.
  - Next edge: latch minas_in, load minas_total=popcount, clear revelado and revelados_cnt, clear perdido and ganado.
  - Next state is JUGANDO, or GANADO if minas_total==64 (no safe cells).
- JUGANDO:
  - sel_listo=1.
  - On transfer: latch idx = sel_fila*8 + sel_col, go to REVELA.
  - sel_valido in any other state is ignored; no queueing.
- REVELA (1 cycle, ocupado=1):
  - Cell already revealed: no change, back to JUGANDO.
  - Cell is a mine: revelado |= mine bitmap, perdido=1, go to PERDIDO.
  - Otherwise: set the cell's bit and increment revelados_cnt.
    - If the cell is zero (no mine among its up-to-8 in-board neighbours), go to BARRIDO with scan idx=0 and cambio=0.
    - Else go to JUGANDO.
- Zero test:
  - Computed from the latched mine bitmap only; the generator's 3-bit counts are not used.
  - This avoids ambiguity when a count of 8 wraps to 0.
  - Edge and corner cells consider in-board neighbours only; no wrap between row ends or between top and bottom.
- BARRIDO (ocupado=1, sel_listo=0):
  - One cell per cycle, idx 0..63.
  - Reveal cell idx if all of the following hold: it is unrevealed, it is not a mine, and some in-board neighbour is revealed and zero.
  - Each reveal sets cambio=1 and increments revelados_cnt.
  - A reveal is visible to later cells in the same sweep, because the current register is read.
  - At idx=63: if cambio=1, restart at idx 0 with cambio=0; else leave BARRIDO.
  - Sweep length is exactly 64 cycles; the number of sweeps is data-dependent and at most 64.
- Win check:
  - On every exit from REVELA or BARRIDO toward JUGANDO, if revelados_cnt == 64 - minas_total, go to GANADO (ganado=1) instead.
- PERDIDO and GANADO:
  - sel_listo=0; outputs frozen; only carga or reset leaves.
- Counter widths: revelados_cnt never exceeds 64 - minas_total; no saturation logic is required.

Decomposition:
- Package revelar_pkg holds:
  - the state enum estado_t;
  - constants N, CELDAS=64;
  - a function idx(fila,col);
  - a function vecino_valido(idx,dfila,dcol).
- One sub-module, es_cero: combinational.
  - Inputs: 64-bit mine bitmap, 6-bit idx.
  - Output: 1 if no in-board neighbour is a mine.
  - Instantiated twice in the top: once for the REVELA cell, once for the neighbour test in BARRIDO via a zero-mask.
  - Alternatively it produces a full 64-bit zero-mask computed once after carga.

Test Plan:
- Reset mid-BARRIDO: rst_n low for 1 cycle during a sweep -> revelado=0, ocupado=0, state SIN_TABLERO, sel_listo=0.
- Mine hit: minas_in bit 9 only, carga, select (1,1) -> perdido=1 two edges after transfer, revelado=64'h200, sel_listo=0, later selects ignored.
- Numbered cell: mine at idx 0, select (0,1) -> revelado=64'h2, revelados_cnt=1, back in JUGANDO after 1 REVELA cycle, no sweep.
- Flood and win: single mine at idx 63, select (0,0) -> sweeps run; final revelado = ~(1<<63), revelados_cnt=63, ganado=1, ocupado low.
- Simultaneous carga and select in JUGANDO: carga wins -> board reloaded, revelado=0, no cell revealed.
- Repeat select of revealed cell plus full-board edge: re-select (0,1) after the numbered-cell case -> revelados_cnt unchanged. minas_in=all ones, carga -> ganado=1 next cycle, minas_total=64.
